// File: rtl/input_pio_irq.sv
// Avalon-MM input PIO: synchronised, debounced inputs with a W1C edge-capture
// register and a maskable level interrupt. Registered readdata, one-cycle latency.
module input_pio_irq #(
  parameter int WIDTH           = 18,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int N  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(N);

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  reg_addr_e          addr_e;
  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   sync;
  logic [CW-1:0]      cnt [WIDTH];
  logic [WIDTH-1:0]   stable;
  logic [WIDTH-1:0]   load;
  logic [WIDTH-1:0]   edge_set;
  logic [WIDTH-1:0]   edge_clr;
  logic [WIDTH-1:0]   irq_mask;
  logic [WIDTH-1:0]   edge_capture;
  logic [31:0]        rd_next;
  logic               wr_en;
  logic               unused_wdata;

  assign addr_e       = reg_addr_e'(address);
  assign wr_en        = chipselect && !write_n;
  assign sync         = sync_q[SYNC_STAGES-1];
  assign unused_wdata = ^writedata;

  // NOTE: the synchroniser chain is an array of flops, not a RAM, so it is
  // reset like any other register; there is no state left over after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A bit is accepted on the edge where its mismatch has been seen N times in a row.
  always_comb begin
    load = '0;
    for (int i = 0; i < WIDTH; i++)
      load[i] = (sync[i] != stable[i]) && (cnt[i] == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      stable <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync[i] == stable[i]) || load[i]) cnt[i] <= '0;
        else if (cnt[i] != CNT_MAX)            cnt[i] <= cnt[i] + CW'(1);
      end
      stable <= (stable & ~load) | (sync & load);
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statements can leave a value held and infer a latch.
  always_comb begin
    edge_set = '0;
    case (EDGE_TYPE)
      0:       edge_set = load & sync;
      1:       edge_set = load & ~sync;
      default: edge_set = load;
    endcase
  end

  always_comb begin
    edge_clr = '0;
    if (wr_en && (addr_e == ADDR_EDGE)) edge_clr = writedata[WIDTH-1:0];
  end

  // A new edge overrides a same-cycle W1C clear of that bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (addr_e == ADDR_MASK)) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
    end
  end

  always_comb begin
    rd_next = '0;
    case (addr_e)
      ADDR_DATA: rd_next[WIDTH-1:0] = stable;
      ADDR_MASK: rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_next[WIDTH-1:0] = edge_capture;
      default:   rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_input_pio_irq.sv
// Directed bench for input_pio_irq: one instance without filtering (rising edges)
// and one with a 4-cycle debouncer (any edge), sharing the bus and clock.
module tb_input_pio_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [17:0] in_port_a;
  logic [17:0] in_port_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  input_pio_irq #(
    .WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_a),
    .readdata(readdata_a), .irq(irq_a)
  );

  input_pio_irq #(
    .WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port_a  = 18'h2A5A5;
    in_port_b  = '0;

    // Reset and readback
    tick(3);
    check("reset_readdata", readdata_a, 32'h0);
    check("reset_irq", 32'(irq_a), 32'h0);
    reset_n = 1'b1;
    tick(4);
    rd_reg(2'd0);
    check("data_readback", readdata_a, 32'h0002A5A5);
    rd_reg(2'd1);
    check("reserved_read", readdata_a, 32'h0);
    rd_reg(2'd3);
    check("capture_after_reset", readdata_a, 32'h0002A5A5);
    check("irq_masked_after_reset", 32'(irq_a), 32'h0);
    wr_reg(2'd3, 32'h0003FFFF);
    rd_reg(2'd3);
    check("capture_cleared", readdata_a, 32'h0);

    // Falling edges do not capture on the rising-edge instance
    in_port_a = '0;
    tick(6);
    rd_reg(2'd3);
    check("no_fall_capture", readdata_a, 32'h0);

    // Rising capture and irq latency
    wr_reg(2'd2, 32'h1);
    in_port_a = 18'h00001;
    tick(1);
    check("irq_edge_k", 32'(irq_a), 32'h0);
    tick(1);
    check("irq_edge_k1", 32'(irq_a), 32'h0);
    tick(1);
    check("irq_edge_k2", 32'(irq_a), 32'h1);
    rd_reg(2'd3);
    check("capture_bit0", readdata_a, 32'h1);
    wr_reg(2'd3, 32'h1);
    check("irq_after_w1c", 32'(irq_a), 32'h0);

    // Mask gating
    wr_reg(2'd2, 32'h0);
    in_port_a = 18'h00021;
    tick(4);
    check("irq_masked", 32'(irq_a), 32'h0);
    rd_reg(2'd3);
    check("capture_bit5", readdata_a, 32'h20);
    wr_reg(2'd2, 32'h20);
    check("irq_unmasked", 32'(irq_a), 32'h1);
    rd_reg(2'd2);
    check("mask_readback", readdata_a, 32'h20);
    wr_reg(2'd3, 32'h20);
    check("irq_cleared_bit5", 32'(irq_a), 32'h0);

    // Debounce: 3-cycle pulse rejected
    in_port_b = 18'h00004;
    tick(3);
    in_port_b = '0;
    tick(10);
    rd_reg(2'd0);
    check("glitch_data", readdata_b, 32'h0);
    rd_reg(2'd3);
    check("glitch_capture", readdata_b, 32'h0);

    // Debounce: held level accepted at SYNC_STAGES+3 edges after first sample
    wr_reg(2'd2, 32'h4);
    in_port_b = 18'h00004;
    tick(5);
    check("debounce_irq_early", 32'(irq_b), 32'h0);
    tick(1);
    check("debounce_irq_on_time", 32'(irq_b), 32'h1);
    rd_reg(2'd3);
    check("debounce_capture", readdata_b, 32'h4);
    rd_reg(2'd0);
    check("debounce_data", readdata_b, 32'h4);

    // Collision: W1C of bits 2 and 0 on the edge bit 2 captures a falling edge
    wr_reg(2'd3, 32'h4);
    in_port_b = 18'h00005;
    tick(8);
    rd_reg(2'd3);
    check("pre_collision_capture", readdata_b, 32'h1);
    in_port_b = 18'h00001;
    tick(5);
    check("pre_collision_irq", 32'(irq_b), 32'h0);
    wr_reg(2'd3, 32'h5);
    check("collision_irq", 32'(irq_b), 32'h1);
    rd_reg(2'd3);
    check("collision_capture", readdata_b, 32'h4);

    // Reset mid-operation
    in_port_a = 18'h00020;
    tick(5);
    in_port_a = 18'h00031;
    tick(5);
    wr_reg(2'd2, 32'h0003FFFF);
    in_port_a = '0;
    tick(5);
    rd_reg(2'd3);
    check("pre_reset_capture", readdata_a, 32'h11);
    check("pre_reset_irq", 32'(irq_a), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_irq", 32'(irq_a), 32'h0);
    check("async_reset_readdata", readdata_a, 32'h0);
    reset_n = 1'b1;
    tick(8);
    rd_reg(2'd2);
    check("post_reset_mask", readdata_a, 32'h0);
    rd_reg(2'd3);
    check("post_reset_capture_a", readdata_a, 32'h0);
    check("post_reset_capture_b", readdata_b, 32'h1);
    check("post_reset_irq", 32'(irq_a), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
